// File: rtl/mux8_sel.sv
// 8-to-1 selection primitive: combinational y = d[a] plus a one-cycle registered copy y_q.
// y_q clears asynchronously on reset; y keeps tracking the inputs regardless of clk/reset.
module mux8_sel #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       a,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  logic [WIDTH-1:0] y_d;

  // Default arm only matters for an X/Z select in simulation: propagate X rather than pick an input.
  always_comb begin
    y = {WIDTH{1'bx}};
    case (a)
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      3'd5:    y = d5;
      3'd6:    y = d6;
      3'd7:    y = d7;
      default: y = {WIDTH{1'bx}};
    endcase
  end

  assign y_d = y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) y_q <= '0;
    else       y_q <= y_d;
  end

endmodule

// File: tb/tb_mux8_sel.sv
// Directed bench for mux8_sel: vector table, exhaustive WIDTH=1 sweep, registered/reset sequences, WIDTH=8 sweep.
module tb_mux8_sel;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    logic       y_exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [2:0] a1;
  logic [7:0] dv;
  logic [0:0] y1, yq1;
  logic [2:0] a8;
  logic [7:0] y8, yq8;

  int n_vec;
  int n_err;

  mux8_sel #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .a(a1),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .d4(dv[4]), .d5(dv[5]), .d6(dv[6]), .d7(dv[7]),
    .y(y1), .y_q(yq1)
  );

  mux8_sel #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .a(a8),
    .d0(8'h10), .d1(8'h11), .d2(8'h12), .d3(8'h13),
    .d4(8'h14), .d5(8'h15), .d6(8'h16), .d7(8'h17),
    .y(y8), .y_q(yq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [7:0] exp8;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    a1 = 3'd0;
    dv = 8'h00;
    a8 = 3'd0;

    // Walking one / walking zero, then the specific d5 vector; bit i of d is input d_i.
    for (int i = 0; i < 8; i++) begin
      v.a = 3'(i); v.d = 8'(1 << i);  v.y_exp = 1'b1; tbl.push_back(v);
      v.a = 3'(i); v.d = ~8'(1 << i); v.y_exp = 1'b0; tbl.push_back(v);
    end
    v.a = 3'b101; v.d = 8'b0010_0000; v.y_exp = 1'b1; tbl.push_back(v);
    v.a = 3'b100; v.d = 8'b0010_0000; v.y_exp = 1'b0; tbl.push_back(v);

    // Reset asserted between edges; y must stay live during reset.
    #1 reset = 1'b1;
    a1 = 3'd5; dv = 8'b0010_0000;
    #1;
    chk("reset_yq1", {7'b0, yq1}, 8'h00);
    chk("reset_yq8", yq8, 8'h00);
    chk("y_during_reset", {7'b0, y1}, 8'h01);
    a8 = 3'd6;
    #1 chk("y8_during_reset", y8, 8'h16);
    @(posedge clk); #1;
    chk("reset_hold_yq1", {7'b0, yq1}, 8'h00);
    chk("reset_hold_yq8", yq8, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      a1 = tbl[i].a;
      dv = tbl[i].d;
      #1 chk($sformatf("table[%0d] a=%0d d=%b", i, tbl[i].a, tbl[i].d), {7'b0, y1}, {7'b0, tbl[i].y_exp});
    end

    // Exhaustive: drive 1 ns after rising edge, check on falling edge.
    for (int s = 0; s < 8; s++) begin
      for (int p = 0; p < 256; p++) begin
        @(posedge clk); #1;
        a1 = 3'(s);
        dv = 8'(p);
        @(negedge clk);
        chk($sformatf("exh a=%0d d=%b", s, p[7:0]), {7'b0, y1}, {7'b0, 1'((p >> s) & 1)});
      end
    end

    // Registered path latency.
    @(negedge clk);
    a1 = 3'd2; dv = 8'b0000_0100;
    @(posedge clk); #1;
    chk("reg_capture_a2", {7'b0, yq1}, 8'h01);
    a1 = 3'd3; dv = 8'b0000_0100;
    #1;
    chk("reg_y_immediate", {7'b0, y1}, 8'h00);
    chk("reg_yq_not_yet", {7'b0, yq1}, 8'h01);
    @(posedge clk); #1;
    chk("reg_yq_after_edge", {7'b0, yq1}, 8'h00);

    // Mid-operation async reset.
    @(negedge clk);
    a1 = 3'd2; dv = 8'b0000_0100;
    @(posedge clk); #1;
    chk("pre_reset_yq", {7'b0, yq1}, 8'h01);
    #2 reset = 1'b1;
    #1;
    chk("async_clear_yq", {7'b0, yq1}, 8'h00);
    chk("async_y_unchanged", {7'b0, y1}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("released_yq_waits", {7'b0, yq1}, 8'h00);
    @(posedge clk); #1;
    chk("released_yq_follows", {7'b0, yq1}, 8'h01);

    // WIDTH=8 sweep with one-cycle registered echo.
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      a8 = 3'(s);
      exp8 = 8'h10 + 8'(s);
      #1 chk($sformatf("w8_y a=%0d", s), y8, exp8);
      @(posedge clk); #1;
      chk($sformatf("w8_yq a=%0d", s), yq8, exp8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
